netlist_bist_ctrl: RTL and testbench
====================================

# netlist_bist_ctrl

Self-test controller that sits on the other end of a mapped combinational netlist under test: it generates pseudo-random input vectors for the netlist's 14 primary inputs and compacts its 8 primary outputs into a signature. Used in the contest flow to check that an optimized or remapped netlist still matches a golden signature, with no external vector files. One instance wraps one DUT netlist; the DUT stays purely combinational and outside this block.

## Interface
Parameters:
- IN_W, 14, DUT primary-input count (1..16)
- OUT_W, 8, DUT primary-output count (1..16)
- NUM_PATTERNS, 256, vectors applied per run (2..65535)
- SETTLE, 1, cycles each vector is held before capture (1..15)
- LFSR_SEED, 16'hACE1, nonzero LFSR start value
- POLY, 16'hB400, Galois polynomial shared by LFSR and MISR

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin run; sampled only in IDLE
- abort  in  1  cancel run; return to IDLE, no done
- golden_sig  in  16  expected signature, sampled at DONE
- dut_out  in  OUT_W  DUT primary outputs
- dut_in  out  IN_W  DUT primary inputs, registered
- busy  out  1  high from SEED through last CAPTURE
- done  out  1  one-cycle pulse at run end
- pass  out  1  signature==golden_sig, valid from done until next start
- signature  out  16  current MISR value

## Operation
- FSM states: IDLE, SEED, APPLY, CAPTURE, DONE.
- IDLE: start=1 -> SEED. start while busy ignored.
- SEED: lfsr<=LFSR_SEED, misr<=0, cnt<=0, settle<=0, pass<=0 -> APPLY.
- APPLY: dut_in = lfsr[IN_W-1:0]; settle increments; at settle==SETTLE-1 -> CAPTURE.
- CAPTURE: misr <= (misr>>1) ^ (misr[0] ? POLY : 0) ^ {zero-extend dut_out}; lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0); cnt++; settle<=0. If cnt==NUM_PATTERNS-1 -> DONE else -> APPLY.
- DONE: done=1, pass <= (misr==golden_sig) -> IDLE.
- abort=1 in any non-IDLE state: -> IDLE next cycle, busy=0, done stays 0, signature holds partial value, pass=0.
- LFSR never reaches zero (nonzero seed, maximal polynomial); 16-bit wrap of internal counters impossible within NUM_PATTERNS bounds.
- dut_out widths < 16 zero-extend on the high side.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, signature=0, state IDLE.
- rst wins over start and abort in the same cycle; rst mid-run returns all outputs to reset values next cycle.
- start at cycle t -> SEED at t+1 (busy=1) -> first dut_in visible at t+2.
- Each pattern occupies SETTLE+1 cycles (SETTLE APPLY + 1 CAPTURE); dut_in changes on the cycle after CAPTURE.
- dut_out sampled in the CAPTURE cycle, i.e. after dut_in has been stable ≥SETTLE cycles.
- busy high for 1+NUM_PATTERNS*(SETTLE+1) cycles; done asserted the cycle after busy falls.
- start in the DONE cycle is ignored; accepted from the next IDLE cycle.

## Structure
- Shared package: POLY default, LFSR_SEED default, FSM state enum, galois_step function (used for both LFSR and MISR).
- One sub-module natural: bist_misr (16-bit MISR with load-zero and update enable); LFSR inline via galois_step.

## Test plan
- Zero DUT (dut_out=0), NUM_PATTERNS=4, SETTLE=1: signature=16'h0000 at done, golden_sig=0 -> pass=1; busy high exactly 9 cycles.
- Vector sequence, IN_W=14: first dut_in=14'h2CE1, second 14'h2270 (lfsr 16'hE270); each held SETTLE cycles plus capture.
- Identity-style DUT (dut_out = dut_in[7:0]), golden_sig from behavioural model -> pass=1; flip golden_sig bit 0 -> pass=0.
- abort asserted mid-run at pattern 2 -> IDLE next cycle, busy=0, done never pulses, new start restarts at dut_in=14'h2CE1.
- rst asserted in CAPTURE with start also high -> all outputs reset next cycle, state IDLE, no run begins.
- start held high through DONE: exactly one done pulse; second run starts only from the following IDLE cycle.

Source files
------------

// File: rtl/netlist_bist_ctrl_pkg.sv
// Shared definitions for the netlist BIST controller: defaults, FSM encoding
// and the Galois shift step used by both the pattern LFSR and the MISR.
package netlist_bist_ctrl_pkg;

  localparam logic [15:0] DEF_POLY      = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } bist_state_t;

  function automatic logic [15:0] galois_step(input logic [15:0] value,
                                              input logic [15:0] poly);
    return (value >> 1) ^ (value[0] ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/netlist_bist_ctrl_misr.sv
// 16-bit multiple-input signature register; clr zeroes it, en folds in one
// response word per capture.
module bist_misr
  import netlist_bist_ctrl_pkg::*;
#(
  parameter logic [15:0] POLY = DEF_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data_in,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= galois_step(sig, POLY) ^ data_in;
    end
  end

endmodule

// File: rtl/netlist_bist_ctrl.sv
// Pattern generator and response compactor wrapped around one combinational
// netlist under test; compares the final signature against golden_sig.
//
// state      | meaning
// IDLE       | waiting for start; pass holds last result
// SEED       | load LFSR, clear MISR and counters
// APPLY      | vector on dut_in, waiting for the netlist to settle
// CAPTURE    | fold dut_out into MISR, advance LFSR
// DONE       | one-cycle done pulse, latch the compare result
module netlist_bist_ctrl
  import netlist_bist_ctrl_pkg::*;
#(
  parameter int          IN_W         = 14,
  parameter int          OUT_W        = 8,
  parameter int          NUM_PATTERNS = 256,
  parameter int          SETTLE       = 1,
  parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED,
  parameter logic [15:0] POLY         = DEF_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      golden_sig,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);

  bist_state_t state, state_nxt;
  logic [15:0] lfsr;
  logic [15:0] pat_cnt;
  logic [3:0]  settle_cnt;
  logic [15:0] dut_out_ext;
  logic        pass_q;
  logic        seed_en;
  logic        capture_en;
  logic        abort_run;

  assign abort_run = abort && (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_run) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) state_nxt = ST_SEED;
        ST_SEED:    state_nxt = ST_APPLY;
        ST_APPLY:   if (settle_cnt == '0) state_nxt = ST_CAPTURE;
        ST_CAPTURE: state_nxt = (pat_cnt == '0) ? ST_DONE : ST_APPLY;
        ST_DONE:    state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // The compare is live during DONE so pass is already valid with the done pulse.
  always_comb begin
    seed_en    = (state == ST_SEED) && !abort_run;
    capture_en = (state == ST_CAPTURE) && !abort_run;
    busy       = (state == ST_SEED) || (state == ST_APPLY) || (state == ST_CAPTURE);
    done       = (state == ST_DONE) && !abort_run;
    pass       = done ? (signature == golden_sig) : pass_q;
  end

  // Settle and pattern counters run down to a terminal count of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= '0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
      pass_q     <= 1'b0;
    end else if (abort_run) begin
      pass_q <= 1'b0;
    end else begin
      if (seed_en) begin
        lfsr       <= LFSR_SEED;
        pat_cnt    <= 16'(NUM_PATTERNS - 1);
        settle_cnt <= 4'(SETTLE - 1);
        pass_q     <= 1'b0;
      end
      if (state == ST_APPLY && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture_en) begin
        lfsr       <= galois_step(lfsr, POLY);
        settle_cnt <= 4'(SETTLE - 1);
        if (pat_cnt != '0) pat_cnt <= pat_cnt - 16'd1;
      end
      if (done) begin
        pass_q <= pass;
      end
    end
  end

  always_comb begin
    dut_out_ext = '0;
    dut_out_ext[OUT_W-1:0] = dut_out;
  end

  assign dut_in = lfsr[IN_W-1:0];

  bist_misr #(
    .POLY(POLY)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .clr    (seed_en),
    .en     (capture_en),
    .data_in(dut_out_ext),
    .sig    (signature)
  );

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Self-checking bench for netlist_bist_ctrl: table of full runs against a
// behavioural LFSR/MISR model, plus abort, reset and start-held sequences.
module tb_netlist_bist_ctrl;

  localparam int          IN_W   = 14;
  localparam int          OUT_W  = 8;
  localparam int          NP     = 4;
  localparam int          SETTLE = 1;
  localparam logic [15:0] SEED_V = 16'hACE1;
  localparam logic [15:0] POLY_V = 16'hB400;

  typedef struct {
    string       name;
    logic        ident;
    logic        use_model;
    logic [15:0] gxor;
    logic        exp_pass;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             ident;
  logic [15:0]      golden_sig;
  logic [OUT_W-1:0] dut_out;
  logic [IN_W-1:0]  dut_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      signature;

  int errors = 0;
  int checks = 0;
  logic [IN_W-1:0] exp_q[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  assign dut_out = ident ? dut_in[7:0] : '0;

  netlist_bist_ctrl #(
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .NUM_PATTERNS(NP),
    .SETTLE      (SETTLE),
    .LFSR_SEED   (SEED_V),
    .POLY        (POLY_V)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .golden_sig(golden_sig),
    .dut_out   (dut_out),
    .dut_in    (dut_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    logic [15:0] s;
    s = {1'b0, v[15:1]};
    if (v[0]) s = s ^ POLY_V;
    return s;
  endfunction

  // Pushes the expected vector sequence and returns the signature after n_cap captures.
  task automatic model_run(input logic id, input int n_cap, output logic [15:0] sig);
    logic [15:0] l;
    l = SEED_V;
    sig = 16'h0000;
    exp_q.delete();
    for (int k = 0; k < NP; k++) begin
      exp_q.push_back(l[IN_W-1:0]);
      if (k < n_cap) sig = step(sig) ^ (id ? {8'h00, l[7:0]} : 16'h0000);
      l = step(l);
    end
  endtask

  task automatic check_pattern(input string name, input int s);
    logic [IN_W-1:0] e;
    e = '0;
    if (s == 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty, got dut_in 0x%0h", name, dut_in);
      end else begin
        e = exp_q.pop_front();
        check({name, " dut_in"}, 16'(dut_in), 16'(e));
      end
    end
  endtask

  task automatic run_full(input vec_t v);
    logic [15:0]     msig;
    logic [IN_W-1:0] held;
    int              busy_n;
    ident = v.ident;
    model_run(v.ident, NP, msig);
    golden_sig = (v.use_model ? msig : 16'h0000) ^ v.gxor;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_n = int'(busy);
    check({v.name, " seed busy"}, 16'(busy), 16'd1);
    for (int k = 0; k < NP; k++) begin
      for (int s = 0; s <= SETTLE; s++) begin
        tick();
        busy_n += int'(busy);
        if (s == 0) begin
          held = dut_in;
          check_pattern(v.name, s);
        end else begin
          check({v.name, " dut_in hold"}, 16'(dut_in), 16'(held));
        end
        check({v.name, " no early done"}, 16'(done), 16'd0);
      end
    end
    tick();
    check({v.name, " busy cycles"}, 16'(busy_n), 16'(1 + NP * (SETTLE + 1)));
    check({v.name, " busy low at done"}, 16'(busy), 16'd0);
    check({v.name, " done"}, 16'(done), 16'd1);
    check({v.name, " signature"}, signature, msig);
    check({v.name, " pass at done"}, 16'(pass), 16'(v.exp_pass));
    tick();
    check({v.name, " done pulse"}, 16'(done), 16'd0);
    check({v.name, " pass held"}, 16'(pass), 16'(v.exp_pass));
  endtask

  initial begin
    logic [15:0] psig;
    int          n_done;

    vecs[0] = '{"zero_dut", 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{"zero_dut_badgold", 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[2] = '{"ident_model", 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{"ident_flip0", 1'b1, 1'b1, 16'h0001, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ident = 1'b0;
    golden_sig = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    check("reset dut_in", 16'(dut_in), 16'd0);
    check("reset busy", 16'(busy), 16'd0);
    check("reset done", 16'(done), 16'd0);
    check("reset pass", 16'(pass), 16'd0);
    check("reset signature", signature, 16'h0000);

    // First two vectors against hand-computed constants, then abort in APPLY.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("vec0", 16'(dut_in), 16'h2CE1);
    tick();
    check("vec0 hold", 16'(dut_in), 16'h2CE1);
    tick();
    check("vec1", 16'(dut_in), 16'h2270);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort early busy", 16'(busy), 16'd0);

    for (int i = 0; i < 4; i++) run_full(vecs[i]);

    // Abort while pattern 2 is applied.
    ident = 1'b1;
    model_run(1'b1, 2, psig);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2 * (SETTLE + 1); c++) tick();
    tick();
    check("abort pat2 dut_in", 16'(dut_in), 16'(exp_q[2]));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", 16'(busy), 16'd0);
    check("abort done", 16'(done), 16'd0);
    check("abort pass", 16'(pass), 16'd0);
    check("abort partial sig", signature, psig);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_done += int'(done);
    end
    check("abort no done", 16'(n_done), 16'd0);
    run_full(vecs[2]);

    // Reset during the second CAPTURE with start also high.
    ident = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2 * (SETTLE + 1); c++) tick();
    check("pre-rst sig nonzero", 16'(signature != 16'h0000), 16'd1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst dut_in", 16'(dut_in), 16'd0);
    check("rst busy", 16'(busy), 16'd0);
    check("rst done", 16'(done), 16'd0);
    check("rst pass", 16'(pass), 16'd0);
    check("rst signature", signature, 16'h0000);
    tick();
    check("rst no run", 16'(busy), 16'd0);

    // start held high across DONE: one done, restart only from the next IDLE.
    model_run(1'b1, NP, psig);
    golden_sig = psig;
    start = 1'b1;
    tick();
    n_done = 0;
    for (int c = 0; c < NP * (SETTLE + 1); c++) begin
      tick();
      n_done += int'(done);
    end
    tick();
    n_done += int'(done);
    check("held done", 16'(done), 16'd1);
    tick();
    n_done += int'(done);
    check("held idle busy", 16'(busy), 16'd0);
    tick();
    n_done += int'(done);
    check("held restart busy", 16'(busy), 16'd1);
    check("held one done", 16'(n_done), 16'd1);
    start = 1'b0;
    for (int c = 0; c < NP * (SETTLE + 1); c++) tick();
    tick();
    check("held run2 done", 16'(done), 16'd1);
    check("held run2 pass", 16'(pass), 16'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
